// File: rtl/axi_upsizer_pkg.sv
// Shared types and helpers for the AXI narrow-to-wide memory bridge.
package axi_upsizer_pkg;

    localparam int ID_MAX_W = 16;
    // Low address bits tracked per burst; AXI bursts never cross 4 KB.
    localparam int OFF_W    = 12;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [OFF_W-1:0]    addr;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic [7:0]          len;
    } rd_entry_t;

    function automatic logic [OFF_W-1:0] next_addr(
        input logic [OFF_W-1:0] addr,
        input logic [2:0]       size,
        input logic [1:0]       burst,
        input logic [7:0]       len
    );
        logic [OFF_W-1:0] step;
        logic [OFF_W-1:0] incr;
        logic [OFF_W-1:0] mask;
        step = OFF_W'(1) << size;
        incr = (addr & ~(step - OFF_W'(1))) + step;
        mask = ((OFF_W'(len) + OFF_W'(1)) << size) - OFF_W'(1);
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | (incr & mask);
            default:     return incr;
        endcase
    endfunction

endpackage

// File: rtl/axi_upsizer_rd_fifo.sv
// Synchronous FIFO tracking outstanding read bursts; push while full is allowed when popping.
module axi_upsizer_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_mem_upsizer.sv
// AXI4 core-to-DDR bridge: address remap, narrow-to-wide lane steering, ID save/restore.
// Optional protocol checks with sticky err_flags when AXI_UPSIZER_CHECK_EN is defined.
module axi_mem_upsizer
    import axi_upsizer_pkg::*;
#(
    parameter int                  S_ADDR_W = 32,
    parameter int                  M_ADDR_W = 49,
    parameter int                  S_DATA_W = 64,
    parameter int                  M_DATA_W = 128,
    parameter int                  S_ID_W   = 4,
    parameter int                  M_ID_W   = 6,
    parameter int                  WIN_BITS = 28,
    parameter logic [M_ADDR_W-1:0] MEM_BASE = 'h1000_0000,
    parameter int                  RD_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    s_aw_valid,
    output logic                    s_aw_ready,
    input  logic [S_ID_W-1:0]       s_aw_id,
    input  logic [S_ADDR_W-1:0]     s_aw_addr,
    input  logic [7:0]              s_aw_len,
    input  logic [2:0]              s_aw_size,
    input  logic [1:0]              s_aw_burst,
    input  logic                    s_aw_lock,
    input  logic [3:0]              s_aw_cache,
    input  logic [2:0]              s_aw_prot,
    input  logic [3:0]              s_aw_qos,
    input  logic                    s_w_valid,
    output logic                    s_w_ready,
    input  logic [S_DATA_W-1:0]     s_w_data,
    input  logic [S_DATA_W/8-1:0]   s_w_strb,
    input  logic                    s_w_last,
    output logic                    s_b_valid,
    input  logic                    s_b_ready,
    output logic [S_ID_W-1:0]       s_b_id,
    output logic [1:0]              s_b_resp,
    input  logic                    s_ar_valid,
    output logic                    s_ar_ready,
    input  logic [S_ID_W-1:0]       s_ar_id,
    input  logic [S_ADDR_W-1:0]     s_ar_addr,
    input  logic [7:0]              s_ar_len,
    input  logic [2:0]              s_ar_size,
    input  logic [1:0]              s_ar_burst,
    input  logic                    s_ar_lock,
    input  logic [3:0]              s_ar_cache,
    input  logic [2:0]              s_ar_prot,
    input  logic [3:0]              s_ar_qos,
    output logic                    s_r_valid,
    input  logic                    s_r_ready,
    output logic [S_ID_W-1:0]       s_r_id,
    output logic [S_DATA_W-1:0]     s_r_data,
    output logic [1:0]              s_r_resp,
    output logic                    s_r_last,
    output logic                    m_aw_valid,
    input  logic                    m_aw_ready,
    output logic [M_ID_W-1:0]       m_aw_id,
    output logic [M_ADDR_W-1:0]     m_aw_addr,
    output logic [7:0]              m_aw_len,
    output logic [2:0]              m_aw_size,
    output logic [1:0]              m_aw_burst,
    output logic                    m_aw_lock,
    output logic [3:0]              m_aw_cache,
    output logic [2:0]              m_aw_prot,
    output logic [3:0]              m_aw_qos,
    output logic                    m_w_valid,
    input  logic                    m_w_ready,
    output logic [M_DATA_W-1:0]     m_w_data,
    output logic [M_DATA_W/8-1:0]   m_w_strb,
    output logic                    m_w_last,
    input  logic                    m_b_valid,
    output logic                    m_b_ready,
    input  logic [M_ID_W-1:0]       m_b_id,
    input  logic [1:0]              m_b_resp,
    output logic                    m_ar_valid,
    input  logic                    m_ar_ready,
    output logic [M_ID_W-1:0]       m_ar_id,
    output logic [M_ADDR_W-1:0]     m_ar_addr,
    output logic [7:0]              m_ar_len,
    output logic [2:0]              m_ar_size,
    output logic [1:0]              m_ar_burst,
    output logic                    m_ar_lock,
    output logic [3:0]              m_ar_cache,
    output logic [2:0]              m_ar_prot,
    output logic [3:0]              m_ar_qos,
    input  logic                    m_r_valid,
    output logic                    m_r_ready,
    input  logic [M_ID_W-1:0]       m_r_id,
    input  logic [M_DATA_W-1:0]     m_r_data,
    input  logic [1:0]              m_r_resp,
    input  logic                    m_r_last
`ifdef AXI_UPSIZER_CHECK_EN
    ,
    output logic [3:0]              err_flags
`endif
);

    localparam int S_STRB_W = S_DATA_W / 8;
    localparam int M_STRB_W = M_DATA_W / 8;
    localparam int R        = M_DATA_W / S_DATA_W;
    localparam int LB       = $clog2(S_STRB_W);

    // ---------------- write path ----------------
    wr_state_e             r_wstate, w_wstate_nxt;
    logic [M_ADDR_W-1:0]   r_aw_addr;
    logic [S_ID_W-1:0]     r_aw_id;
    logic [7:0]            r_aw_len;
    logic [2:0]            r_aw_size;
    logic [1:0]            r_aw_burst;
    logic                  r_aw_lock;
    logic [3:0]            r_aw_cache;
    logic [2:0]            r_aw_prot;
    logic [3:0]            r_aw_qos;
    logic [OFF_W-1:0]      r_w_addr;
    logic [OFF_W-1:0]      w_w_lane;
    logic                  w_aw_hs;
    logic                  w_w_hs;

    always_comb begin
        w_wstate_nxt = r_wstate;
        s_aw_ready   = 1'b0;
        m_aw_valid   = 1'b0;
        s_w_ready    = 1'b0;
        m_w_valid    = 1'b0;
        s_b_valid    = 1'b0;
        m_b_ready    = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_aw_ready = reset_n;
                if (s_aw_valid && reset_n) w_wstate_nxt = W_ADDR;
            end
            W_ADDR: begin
                m_aw_valid = 1'b1;
                if (m_aw_ready) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_w_ready = m_w_ready;
                m_w_valid = s_w_valid;
                if (s_w_valid && m_w_ready && s_w_last) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_b_valid = m_b_valid;
                m_b_ready = s_b_ready;
                if (m_b_valid && s_b_ready) w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    assign w_aw_hs  = s_aw_valid && s_aw_ready;
    assign w_w_hs   = s_w_valid && s_w_ready;
    assign w_w_lane = (r_w_addr >> LB) & OFF_W'(R - 1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wstate   <= W_IDLE;
            r_aw_addr  <= '0;
            r_aw_id    <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_aw_lock  <= 1'b0;
            r_aw_cache <= '0;
            r_aw_prot  <= '0;
            r_aw_qos   <= '0;
            r_w_addr   <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_aw_addr  <= MEM_BASE | M_ADDR_W'(s_aw_addr[WIN_BITS-1:0]);
                r_aw_id    <= s_aw_id;
                r_aw_len   <= s_aw_len;
                r_aw_size  <= s_aw_size;
                r_aw_burst <= s_aw_burst;
                r_aw_lock  <= s_aw_lock;
                r_aw_cache <= s_aw_cache;
                r_aw_prot  <= s_aw_prot;
                r_aw_qos   <= s_aw_qos;
                r_w_addr   <= s_aw_addr[OFF_W-1:0];
            end else if (w_w_hs) begin
                r_w_addr <= next_addr(r_w_addr, r_aw_size, r_aw_burst, r_aw_len);
            end
        end
    end

    assign m_aw_id    = '0;
    assign m_aw_addr  = r_aw_addr;
    assign m_aw_len   = r_aw_len;
    assign m_aw_size  = r_aw_size;
    assign m_aw_burst = r_aw_burst;
    assign m_aw_lock  = r_aw_lock;
    assign m_aw_cache = r_aw_cache;
    assign m_aw_prot  = r_aw_prot;
    assign m_aw_qos   = r_aw_qos;
    assign m_w_data   = {R{s_w_data}};
    assign m_w_strb   = M_STRB_W'(s_w_strb) << (w_w_lane * S_STRB_W);
    assign m_w_last   = s_w_last;
    assign s_b_id     = r_aw_id;
    assign s_b_resp   = m_b_resp;

    // ---------------- read path ----------------
    logic                  r_ar_held;
    logic [M_ADDR_W-1:0]   r_ar_addr;
    logic [7:0]            r_ar_len;
    logic [2:0]            r_ar_size;
    logic [1:0]            r_ar_burst;
    logic                  r_ar_lock;
    logic [3:0]            r_ar_cache;
    logic [2:0]            r_ar_prot;
    logic [3:0]            r_ar_qos;
    logic                  r_rd_active;
    logic [OFF_W-1:0]      r_rd_addr;
    logic [OFF_W-1:0]      w_rd_addr;
    logic [OFF_W-1:0]      w_rd_lane;
    rd_entry_t             w_push_entry;
    rd_entry_t             w_head;
    logic [$bits(rd_entry_t)-1:0] w_fifo_rdata;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_ar_hs;
    logic                  w_rd_beat;
    logic                  w_pop;
    logic                  w_unused;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.id    = ID_MAX_W'(s_ar_id);
        w_push_entry.addr  = s_ar_addr[OFF_W-1:0];
        w_push_entry.size  = s_ar_size;
        w_push_entry.burst = s_ar_burst;
        w_push_entry.len   = s_ar_len;
    end

    axi_upsizer_rd_fifo #(
        .WIDTH ($bits(rd_entry_t)),
        .DEPTH (RD_DEPTH)
    ) u_rd_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_ar_hs),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_head    = rd_entry_t'(w_fifo_rdata);
    assign m_r_ready = s_r_ready && !w_fifo_empty;
    assign w_rd_beat = m_r_valid && m_r_ready;
    assign w_pop     = w_rd_beat && m_r_last;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the next AR.
    assign s_ar_ready = reset_n && (!w_fifo_full || w_pop) && (!r_ar_held || m_ar_ready);
    assign w_ar_hs    = s_ar_valid && s_ar_ready;
    assign w_rd_addr  = r_rd_active ? r_rd_addr : w_head.addr;
    assign w_rd_lane  = (w_rd_addr >> LB) & OFF_W'(R - 1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ar_held   <= 1'b0;
            r_ar_addr   <= '0;
            r_ar_len    <= '0;
            r_ar_size   <= '0;
            r_ar_burst  <= '0;
            r_ar_lock   <= 1'b0;
            r_ar_cache  <= '0;
            r_ar_prot   <= '0;
            r_ar_qos    <= '0;
            r_rd_active <= 1'b0;
            r_rd_addr   <= '0;
        end else begin
            if (w_ar_hs) begin
                r_ar_held  <= 1'b1;
                r_ar_addr  <= MEM_BASE | M_ADDR_W'(s_ar_addr[WIN_BITS-1:0]);
                r_ar_len   <= s_ar_len;
                r_ar_size  <= s_ar_size;
                r_ar_burst <= s_ar_burst;
                r_ar_lock  <= s_ar_lock;
                r_ar_cache <= s_ar_cache;
                r_ar_prot  <= s_ar_prot;
                r_ar_qos   <= s_ar_qos;
            end else if (m_ar_ready) begin
                r_ar_held <= 1'b0;
            end
            if (w_rd_beat) begin
                r_rd_active <= !m_r_last;
                r_rd_addr   <= next_addr(w_rd_addr, w_head.size, w_head.burst, w_head.len);
            end
        end
    end

    assign m_ar_valid = r_ar_held;
    assign m_ar_id    = '0;
    assign m_ar_addr  = r_ar_addr;
    assign m_ar_len   = r_ar_len;
    assign m_ar_size  = r_ar_size;
    assign m_ar_burst = r_ar_burst;
    assign m_ar_lock  = r_ar_lock;
    assign m_ar_cache = r_ar_cache;
    assign m_ar_prot  = r_ar_prot;
    assign m_ar_qos   = r_ar_qos;
    assign s_r_valid  = m_r_valid && !w_fifo_empty;
    assign s_r_id     = w_head.id[S_ID_W-1:0];
    assign s_r_data   = S_DATA_W'(m_r_data >> (w_rd_lane * S_DATA_W));
    assign s_r_resp   = m_r_resp;
    assign s_r_last   = m_r_last;

    assign w_unused = ^{s_aw_addr, s_ar_addr, w_head, m_b_id, m_r_id};

`ifdef AXI_UPSIZER_CHECK_EN
    logic [7:0] r_w_cnt;
    logic [7:0] r_rd_cnt;
    logic [3:0] r_err;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_w_cnt  <= '0;
            r_rd_cnt <= '0;
            r_err    <= '0;
        end else begin
            if (w_aw_hs)     r_w_cnt <= '0;
            else if (w_w_hs) r_w_cnt <= r_w_cnt + 8'd1;
            if (w_pop)          r_rd_cnt <= '0;
            else if (w_rd_beat) r_rd_cnt <= r_rd_cnt + 8'd1;
            if ((w_aw_hs && s_aw_size > 3'(LB)) || (w_ar_hs && s_ar_size > 3'(LB))) r_err[0] <= 1'b1;
            if (w_w_hs && (s_w_last != (r_w_cnt == r_aw_len)))                    r_err[1] <= 1'b1;
            if (m_r_valid && w_fifo_empty)                                        r_err[2] <= 1'b1;
            if (w_rd_beat && (m_r_last != (r_rd_cnt == w_head.len)))              r_err[3] <= 1'b1;
        end
    end

    assign err_flags = r_err;
`endif

endmodule

// File: tb/tb_axi_mem_upsizer.sv
// Directed self-checking bench for axi_mem_upsizer (default parameters).
module tb_axi_mem_upsizer;
    import axi_upsizer_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         s_aw_valid, s_aw_ready, s_aw_lock;
    logic [3:0]   s_aw_id, s_aw_cache, s_aw_qos;
    logic [31:0]  s_aw_addr;
    logic [7:0]   s_aw_len;
    logic [2:0]   s_aw_size, s_aw_prot;
    logic [1:0]   s_aw_burst;
    logic         s_w_valid, s_w_ready, s_w_last;
    logic [63:0]  s_w_data;
    logic [7:0]   s_w_strb;
    logic         s_b_valid, s_b_ready;
    logic [3:0]   s_b_id;
    logic [1:0]   s_b_resp;
    logic         s_ar_valid, s_ar_ready, s_ar_lock;
    logic [3:0]   s_ar_id, s_ar_cache, s_ar_qos;
    logic [31:0]  s_ar_addr;
    logic [7:0]   s_ar_len;
    logic [2:0]   s_ar_size, s_ar_prot;
    logic [1:0]   s_ar_burst;
    logic         s_r_valid, s_r_ready, s_r_last;
    logic [3:0]   s_r_id;
    logic [63:0]  s_r_data;
    logic [1:0]   s_r_resp;
    logic         m_aw_valid, m_aw_ready, m_aw_lock;
    logic [5:0]   m_aw_id;
    logic [48:0]  m_aw_addr;
    logic [7:0]   m_aw_len;
    logic [2:0]   m_aw_size, m_aw_prot;
    logic [1:0]   m_aw_burst;
    logic [3:0]   m_aw_cache, m_aw_qos;
    logic         m_w_valid, m_w_ready, m_w_last;
    logic [127:0] m_w_data;
    logic [15:0]  m_w_strb;
    logic         m_b_valid, m_b_ready;
    logic [5:0]   m_b_id;
    logic [1:0]   m_b_resp;
    logic         m_ar_valid, m_ar_ready, m_ar_lock;
    logic [5:0]   m_ar_id;
    logic [48:0]  m_ar_addr;
    logic [7:0]   m_ar_len;
    logic [2:0]   m_ar_size, m_ar_prot;
    logic [1:0]   m_ar_burst;
    logic [3:0]   m_ar_cache, m_ar_qos;
    logic         m_r_valid, m_r_ready, m_r_last;
    logic [5:0]   m_r_id;
    logic [127:0] m_r_data;
    logic [1:0]   m_r_resp;
`ifdef AXI_UPSIZER_CHECK_EN
    logic [3:0]   err_flags;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    axi_mem_upsizer u_dut (
        .clock(clock), .reset_n(reset_n),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
        .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_lock(s_aw_lock),
        .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot), .s_aw_qos(s_aw_qos),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
        .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_lock(s_ar_lock),
        .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
        .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr),
        .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock),
        .m_aw_cache(m_aw_cache), .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock),
        .m_ar_cache(m_ar_cache), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
        .m_r_resp(m_r_resp), .m_r_last(m_r_last)
`ifdef AXI_UPSIZER_CHECK_EN
        , .err_flags(err_flags)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        s_ar_valid = 1'b1; s_ar_id = id; s_ar_addr = addr;
        s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
        #1;
        check("ar_ready", s_ar_ready, 1'b1);
        step();
        s_ar_valid = 1'b0;
    endtask

    task automatic r_beat(input string tag, input logic [63:0] hi, input logic [63:0] lo, input logic last,
                          input logic [63:0] exp_data, input logic [3:0] exp_id);
        m_r_valid = 1'b1; m_r_data = {hi, lo}; m_r_last = last; m_r_resp = 2'b00;
        #1;
        check({tag, "_valid"}, s_r_valid, 1'b1);
        check({tag, "_data"}, s_r_data, exp_data);
        check({tag, "_id"}, s_r_id, exp_id);
        check({tag, "_last"}, s_r_last, last);
        step();
        m_r_valid = 1'b0; m_r_last = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        s_aw_valid = 0; s_aw_id = 0; s_aw_addr = 0; s_aw_len = 0; s_aw_size = 0; s_aw_burst = 0;
        s_aw_lock = 0; s_aw_cache = 0; s_aw_prot = 0; s_aw_qos = 0;
        s_w_valid = 0; s_w_data = 0; s_w_strb = 0; s_w_last = 0; s_b_ready = 1;
        s_ar_valid = 0; s_ar_id = 0; s_ar_addr = 0; s_ar_len = 0; s_ar_size = 0; s_ar_burst = 0;
        s_ar_lock = 0; s_ar_cache = 0; s_ar_prot = 0; s_ar_qos = 0; s_r_ready = 1;
        m_aw_ready = 1; m_w_ready = 1; m_b_valid = 0; m_b_id = 0; m_b_resp = 0;
        m_ar_ready = 1; m_r_valid = 0; m_r_id = 0; m_r_data = 0; m_r_resp = 0; m_r_last = 0;

        // Reset state
        step(); step();
        check("rst_aw_ready", s_aw_ready, 1'b0);
        check("rst_ar_ready", s_ar_ready, 1'b0);
        check("rst_valids", {m_aw_valid, m_ar_valid, m_w_valid, s_b_valid, s_r_valid}, 5'b0);
        check("rst_readys", {s_w_ready, m_b_ready, m_r_ready}, 3'b0);
        reset_n = 1'b1;
        #1;
        check("idle_aw_ready", s_aw_ready, 1'b1);
        step();

        // Single write, lane 1
        s_aw_valid = 1; s_aw_id = 4'h5; s_aw_addr = 32'h8000_0048; s_aw_len = 0; s_aw_size = 3;
        s_aw_burst = BURST_INCR; s_aw_qos = 4'h9;
        #1;
        check("wr_aw_ready", s_aw_ready, 1'b1);
        step();
        s_aw_valid = 0;
        #1;
        check("wr_m_aw_valid", m_aw_valid, 1'b1);
        check("wr_m_aw_addr", m_aw_addr, 49'h1000_0048);
        check("wr_m_aw_id", m_aw_id, 6'h0);
        check("wr_m_aw_qos", m_aw_qos, 4'h9);
        check("wr_w_ready_addr", s_w_ready, 1'b0);
        step();
        s_w_valid = 1; s_w_data = 64'h1122_3344_5566_7788; s_w_strb = 8'hFF; s_w_last = 1;
        #1;
        check("wr_m_w_valid", m_w_valid, 1'b1);
        check("wr_m_w_data", m_w_data, 128'h1122_3344_5566_7788_1122_3344_5566_7788);
        check("wr_m_w_strb", m_w_strb, 16'hFF00);
        check("wr_m_w_last", m_w_last, 1'b1);
        check("wr_s_w_ready", s_w_ready, 1'b1);
        step();
        s_w_valid = 0; s_w_last = 0; m_b_valid = 1; m_b_resp = 2'b10;
        #1;
        check("wr_b_valid", s_b_valid, 1'b1);
        check("wr_b_id", s_b_id, 4'h5);
        check("wr_b_resp", s_b_resp, 2'b10);
        step();
        m_b_valid = 0;
        #1;
        check("wr_back_idle", s_aw_ready, 1'b1);

        // INCR read len 3: lanes 0,1,0,1
        issue_ar(4'h7, 32'h8000_0000, 8'd3, 3'd3, BURST_INCR);
        #1;
        check("rd_m_ar_valid", m_ar_valid, 1'b1);
        check("rd_m_ar_addr", m_ar_addr, 49'h1000_0000);
        check("rd_m_ar_id", m_ar_id, 6'h0);
        check("rd_m_ar_len", m_ar_len, 8'd3);
        step();
        r_beat("incr0", 64'hA0, 64'h50, 1'b0, 64'h50, 4'h7);
        r_beat("incr1", 64'hA1, 64'h51, 1'b0, 64'hA1, 4'h7);
        r_beat("incr2", 64'hA2, 64'h52, 1'b0, 64'h52, 4'h7);
        r_beat("incr3", 64'hA3, 64'h53, 1'b1, 64'hA3, 4'h7);

        // Four outstanding reads fill the FIFO; fifth AR waits for the first pop
        for (int i = 1; i <= 4; i++) issue_ar(4'(i), 32'h8000_0100, 8'd0, 3'd3, BURST_INCR);
        s_ar_valid = 1; s_ar_id = 4'h5; s_ar_len = 0;
        #1;
        check("full_ar_stall", s_ar_ready, 1'b0);
        step();
        m_r_valid = 1; m_r_last = 1; m_r_data = {64'hB1, 64'hC1};
        #1;
        check("full_pop_id", s_r_id, 4'h1);
        check("full_ar_on_pop", s_ar_ready, 1'b1);
        step();
        s_ar_valid = 0;
        r_beat("ord2", 64'hB2, 64'hC2, 1'b1, 64'hC2, 4'h2);
        r_beat("ord3", 64'hB3, 64'hC3, 1'b1, 64'hC3, 4'h3);
        r_beat("ord4", 64'hB4, 64'hC4, 1'b1, 64'hC4, 4'h4);
        r_beat("ord5", 64'hB5, 64'hC5, 1'b1, 64'hC5, 4'h5);

        // WRAP len 1 at offset 8: lanes 1,0
        issue_ar(4'h3, 32'h8000_0008, 8'd1, 3'd3, BURST_WRAP);
        step();
        r_beat("wrap0", 64'hD1, 64'hE1, 1'b0, 64'hD1, 4'h3);
        r_beat("wrap1", 64'hD2, 64'hE2, 1'b1, 64'hE2, 4'h3);

        // W arrives before AW and m_aw_ready is held low
        m_aw_ready = 0;
        s_w_valid = 1; s_w_data = 64'hCAFE_0000_BEEF_0001; s_w_strb = 8'h0F; s_w_last = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("early_w_stall", {s_w_ready, m_w_valid}, 2'b00);
            step();
        end
        s_aw_valid = 1; s_aw_id = 4'hA; s_aw_addr = 32'h8000_0000; s_aw_len = 0;
        s_aw_size = 3; s_aw_burst = BURST_INCR;
        #1;
        check("early_aw_ready", s_aw_ready, 1'b1);
        step();
        s_aw_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("early_aw_wait", {m_aw_valid, m_w_valid, s_w_ready}, 3'b100);
            step();
        end
        m_aw_ready = 1;
        step();
        m_aw_ready = 0;
        #1;
        check("early_w_data", m_w_data, 128'hCAFE_0000_BEEF_0001_CAFE_0000_BEEF_0001);
        check("early_w_strb", m_w_strb, 16'h000F);
        check("early_w_hs", {m_w_valid, s_w_ready}, 2'b11);
        step();
        s_w_valid = 0; s_w_last = 0; m_aw_ready = 1; m_b_valid = 1; m_b_resp = 2'b00;
        #1;
        check("early_b_id", s_b_id, 4'hA);
        step();
        m_b_valid = 0;

        // Reset in the middle of a read burst
        issue_ar(4'h2, 32'h8000_0000, 8'd3, 3'd3, BURST_INCR);
        step();
        r_beat("mid0", 64'hF1, 64'hF0, 1'b0, 64'hF0, 4'h2);
        m_r_valid = 1; reset_n = 0;
        step();
        #1;
        check("mid_rst_outs", {s_r_valid, m_r_ready, s_ar_ready, m_ar_valid, s_aw_ready}, 5'b0);
        reset_n = 1;
        #1;
        check("mid_rst_empty", {s_r_valid, m_r_ready}, 2'b00);
        check("mid_rst_ar_ready", s_ar_ready, 1'b1);
        m_r_valid = 0;
        step();

`ifdef AXI_UPSIZER_CHECK_EN
        check("err_clear", err_flags[0], 1'b0);
        issue_ar(4'h1, 32'h8000_0000, 8'd0, 3'd4, BURST_INCR);
        step();
        check("err_size", err_flags[0], 1'b1);
        r_beat("err_beat", 64'h1, 64'h2, 1'b1, 64'h2, 4'h1);
        check("err_sticky", err_flags[0], 1'b1);
        reset_n = 0;
        step();
        reset_n = 1;
        #1;
        check("err_reset", err_flags, 4'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
